// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
// Shared constants for the multi-cycle serial add/sub datapath.
//   - FSM state encodings (kept as plain 2-bit constants so existing code
//     that compares raw state bits keeps working)
//   - operation mode constants
//   - helper that sizes the digit counter
// ---------------------------------------------------------------------------
package serial_pkg;

  // FSM state encodings
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] WORK = 2'b01;
  localparam logic [1:0] DONE = 2'b11;

  // Operation select
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // The digit counter needs clog2(steps) bits, but never fewer than one so
  // that a single-step configuration still has a legal register.
  function automatic int counterWidth(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// ---------------------------------------------------------------------------
// serial_digit_adder
// Purely combinational DIGIT-bit ripple adder used once per work cycle by
// serial_addsub.
//
// Ports:
//   a, b      [DIGIT-1:0]  digit operands
//   cin       1            carry into the digit's LSB
//   s         [DIGIT-1:0]  digit sum
//   cout      1            carry out of the digit's MSB
//   c_msb_in  1            carry into the digit's MSB (for signed overflow)
// ---------------------------------------------------------------------------
module serial_digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  // Ripple the carry bit by bit. The carry entering the top bit is tapped
  // off on the way so the parent can compare it with the final carry out;
  // when DIGIT is 1 that is simply cin.
  always_comb begin
    logic carry;
    s        = '0;
    c_msb_in = 1'b0;
    carry    = cin;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) begin
        c_msb_in = carry;
      end
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
    end
    cout = carry;
  end

endmodule

// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
// Multi-cycle adder/subtractor. Processes DIGIT bits of two WIDTH-bit
// operands per clock, LSB digit first, and reports carry-out and signed
// overflow. Subtraction is A + ~B + 1, so result[WIDTH]=1 means no borrow.
//
// Ports:
//   clock     in   1        rising-edge clock
//   reset     in   1        asynchronous active-high reset
//   start     in   1        request, sampled only in IDLE
//   mode      in   1        0 = A+B, 1 = A-B (sampled with start)
//   A, B      in   WIDTH    operands (sampled with start)
//   busy      out  1        high while digits are being processed
//   done      out  1        one-cycle pulse, result/overflow valid
//   result    out  WIDTH+1  {carry_out, sum}, held until the next done
//   overflow  out  1        two's-complement overflow, held with result
// ---------------------------------------------------------------------------
module serial_addsub
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result,
  output logic             overflow
);

  // Reject configurations the shift/counter scheme cannot handle.
  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_badParams
      $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = counterWidth(STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_aSr;
  logic [WIDTH-1:0] r_bSr;
  logic [WIDTH-1:0] r_sumSr;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic [WIDTH:0]   r_result;
  logic             r_overflow;

  logic [DIGIT-1:0]       w_s;
  logic                   w_cout;
  logic                   w_cMsbIn;
  logic [WIDTH+DIGIT-1:0] w_sumCat;
  logic [WIDTH-1:0]       w_sumNext;
  logic                   w_lastStep;

  serial_digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a       (r_aSr[DIGIT-1:0]),
    .b       (r_bSr[DIGIT-1:0]),
    .cin     (r_carry),
    .s       (w_s),
    .cout    (w_cout),
    .c_msb_in(w_cMsbIn)
  );

  // The new digit enters at the MSB end and everything shifts right by one
  // digit. Building it from a concatenation keeps the slice legal even when
  // a single digit covers the whole word.
  assign w_sumCat   = {w_s, r_sumSr};
  assign w_sumNext  = w_sumCat[WIDTH+DIGIT-1:DIGIT];
  assign w_lastStep = (r_count == LAST_STEP);

  // Control FSM plus operand/sum shift registers. Operands are captured
  // only on the accept edge; the carry is preloaded with mode so that
  // subtraction gets its +1. result/overflow only move on the final digit,
  // so they hold their previous values throughout a new operation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_aSr      <= '0;
      r_bSr      <= '0;
      r_sumSr    <= '0;
      r_carry    <= 1'b0;
      r_count    <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= WORK;
            r_aSr   <= A;
            r_bSr   <= (mode == MODE_SUB) ? ~B : B;
            r_carry <= mode;
            r_count <= '0;
            r_sumSr <= '0;
          end
        end
        WORK: begin
          r_aSr   <= r_aSr >> DIGIT;
          r_bSr   <= r_bSr >> DIGIT;
          r_sumSr <= w_sumNext;
          r_carry <= w_cout;
          r_count <= r_count + CW'(1);
          if (w_lastStep) begin
            r_result   <= {w_cout, w_sumNext};
            // The last digit holds bit WIDTH-1, so its carry-in vs carry-out
            // disagreement is exactly the signed overflow.
            r_overflow <= w_cout ^ w_cMsbIn;
            r_state    <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = (r_state == WORK);
  assign done     = (r_state == DONE);
  assign result   = r_result;
  assign overflow = r_overflow;

endmodule
